// File: rtl/sin_freq_est.sv
// Sine frequency estimator: counts samples over 2^log2navg rising zero-crossing periods and divides into an NCO phase increment.
// Optional macro FEST_HYST_EN arms on fsin_i <= -hyst; otherwise any negative sample arms.
module sin_freq_est #(
    parameter int mpr      = 14,
    parameter int apr      = 32,
    parameter int cntw     = 24,
    parameter int log2navg = 2,
    parameter int hyst     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic signed [mpr-1:0] fsin_i,
    input  logic                  in_valid,
    output logic [apr-1:0]        phi_inc_o,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout
);
    localparam int pw = log2navg + 1;
    localparam int iw = $clog2(apr + 1);
    localparam logic [pw-1:0]   last_period = pw'((1 << log2navg) - 1);
    localparam logic [cntw-1:0] n_max       = '1;
    localparam logic [cntw:0]   navg        = (cntw+1)'(1 << log2navg);
    localparam logic [iw-1:0]   last_iter   = iw'(apr);
`ifdef FEST_HYST_EN
    localparam bit hyst_en = 1'b1;
`else
    localparam bit hyst_en = 1'b0;
`endif
    localparam int arm_level = hyst_en ? -hyst : -1;

    typedef enum logic {IDLE, MEAS} state_t;

    state_t          state_q, state_d;
    logic            armed_q, armed_d;
    logic [cntw-1:0] n_q, n_d, n_inc;
    logic [pw-1:0]   pcnt_q, pcnt_d;
    logic            complete, tmo;

    logic            accept, arm_hit, crossing;

    assign accept   = clken & in_valid;
    assign arm_hit  = int'(fsin_i) <= arm_level;
    assign crossing = armed_q && !fsin_i[mpr-1];
    assign n_inc    = n_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            n_q     <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            n_q     <= n_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        n_d      = n_q;
        pcnt_d   = pcnt_q;
        complete = 1'b0;
        tmo      = 1'b0;
        if (accept) begin
            if (arm_hit)  armed_d = 1'b1;
            if (crossing) armed_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (crossing) begin
                        state_d = MEAS;
                        n_d     = '0;
                        pcnt_d  = '0;
                    end
                end
                MEAS: begin
                    n_d = n_inc;
                    if (crossing) begin
                        if (pcnt_q == last_period) begin
                            complete = 1'b1;
                            n_d      = '0;
                            pcnt_d   = '0;
                        end else begin
                            pcnt_d = pcnt_q + 1'b1;
                        end
                    end
                    // A block that never closes gives up and waits for a fresh crossing.
                    if (!complete && n_inc == n_max) begin
                        tmo     = 1'b1;
                        state_d = IDLE;
                        armed_d = 1'b0;
                        n_d     = '0;
                    end
                end
            endcase
        end
    end

    // Restoring divider for 2^(apr+log2navg) / N. The integer part above apr bits is nonzero
    // exactly when N <= 2^log2navg (saturation); otherwise the partial remainder starts at 2^log2navg.
    logic [iw-1:0]   it_q;
    logic [cntw:0]   rem_q;
    logic [cntw-1:0] div_q;
    logic [apr-1:0]  quo_q;
    logic            sat_q;
    logic [cntw+1:0] rem_sh, rem_sub;
    logic            q_bit, start, iterate, finish;

    assign rem_sh  = {rem_q, 1'b0};
    assign rem_sub = rem_sh - {2'b00, div_q};
    assign q_bit   = rem_sh >= {2'b00, div_q};
    assign start   = complete && !busy;
    assign iterate = busy && (it_q != last_iter);
    assign finish  = busy && (it_q == last_iter);

    // NOTE: the divider datapath carries no reset; busy alone qualifies it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (start) begin
            div_q <= n_inc;
            it_q  <= '0;
            rem_q <= navg;
            quo_q <= '0;
            sat_q <= ({1'b0, n_inc} <= navg);
        end else if (iterate) begin
            rem_q <= (cntw+1)'(q_bit ? rem_sub : rem_sh);
            quo_q <= {quo_q[apr-2:0], q_bit};
            it_q  <= it_q + 1'b1;
        end
    end

    // NOTE: registers take non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            phi_inc_o <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            timeout   <= tmo;
            if (complete && busy) overrun <= 1'b1;
            if (finish) begin
                busy      <= 1'b0;
                out_valid <= 1'b1;
                phi_inc_o <= sat_q ? '1 : quo_q;
            end else if (start) begin
                busy <= 1'b1;
            end
        end
    end
endmodule

// File: doc/sin_freq_est.md
SIN_FREQ_EST -- requirements
Module: sin_freq_est

Interface
REQ-001 Parameter mpr, default 14: input sample width, signed two's complement.
REQ-002 Parameter apr, default 32: phase-increment output width, matching the NCO phase accumulator.
REQ-003 Parameter cntw, default 24: accumulated sample-count width.
REQ-004 Parameter log2navg, default 2: log2 of the number of periods averaged per estimate.
REQ-005 Parameter hyst, default 64: arming threshold magnitude, in LSBs.
REQ-006 clk  input  1  single clock; every register is clocked on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 clken  input  1  sample-path enable.
REQ-009 fsin_i  input  mpr  signed sine sample; format is the NCO fsin_o output.
REQ-010 in_valid  input  1  fsin_i is valid; a sample is accepted on a clk edge where clken=1 and in_valid=1.
REQ-011 phi_inc_o  output  apr  estimated phase increment; held between updates.
REQ-012 out_valid  output  1  one-clk pulse when phi_inc_o updates.
REQ-013 busy  output  1  divider active.
REQ-014 overrun  output  1  sticky; a completed block was discarded.
REQ-015 timeout  output  1  one-clk pulse; no crossing occurred within the count limit.

Function
REQ-016 Sample path: state is IDLE or MEAS, plus an armed flag. It advances only on accepted samples.
REQ-017 Arming: an accepted sample with fsin_i <= -hyst sets armed.
REQ-018 Rising crossing: an accepted sample with armed=1 and fsin_i >= 0. It clears armed.
REQ-019 IDLE: on a crossing, go to MEAS; clear the period count and accumulator.
REQ-020 MEAS: each accepted sample increments the accumulator N. The crossing sample is included in the count.
REQ-021 MEAS: on the 2^log2navg-th crossing, do all of the following in the same edge:
- if busy=0: latch N into the divisor, set busy, restart N=0, stay in MEAS;
- if busy=1: discard N, set overrun, restart N=0.
REQ-022 If N reaches 2^cntw-1 without block completion: pulse timeout, go to IDLE, clear armed.
REQ-023 Divider: unsigned restoring divide of 2^(apr+log2navg) by N. It runs one iteration per clk, independent of clken, for exactly apr iterations.
REQ-024 Latency: block latched at edge k; iterations at edges k+1..k+apr; phi_inc_o = floor quotient and out_valid=1 at edge k+apr+1. busy drops at the same edge.
REQ-025 If the quotient exceeds 2^apr-1, phi_inc_o saturates to 2^apr-1.
REQ-026 Sampling continues during division. Simultaneous block completion and divider finish counts as busy=1 (overrun).

Reset
REQ-027 While reset=1, at each clk edge: state goes to IDLE; armed, N and busy are cleared; the divider is aborted; phi_inc_o=0, out_valid=0, overrun=0, timeout=0.
REQ-028 Reset takes priority over clken and in_valid. A reset asserted mid-divide produces no out_valid.

Configuration
REQ-029 Macro FEST_HYST_EN, when defined: arming per REQ-017.
REQ-030 FEST_HYST_EN undefined: arming on any fsin_i < 0; parameter hyst is ignored.

Verification
REQ-031 Defaults; sine with period 16 samples, amplitude 8000, clken=in_valid=1 -> phi_inc_o=0x10000000, out_valid exactly 33 clks after the 4th crossing edge.
REQ-032 Period 10 samples -> phi_inc_o=0x19999999; out_valid pulses every 40 samples after the first.
REQ-033 cntw=8; armed, then constant fsin_i=-100 -> timeout pulse at the 255th sample; no out_valid; state returns to IDLE.
REQ-034 Period 2 samples (+/-8000), log2navg=0 -> block completes every 2 samples while busy -> overrun=1 and stays 1 until reset.
REQ-035 FEST_HYST_EN defined, sine with amplitude 40 -> no arming, no out_valid. Same stimulus with the macro undefined -> phi_inc_o matches the period.
REQ-036 Reset pulsed at iteration 10 of a divide -> busy=0, phi_inc_o=0, no out_valid; the next full block produces a correct estimate.
